// File: rtl/nf_ram_hs_if.sv
`default_nettype none
// ============================================================================
// nf_ram_hs_if : req/ack bus between an LSU/bus matrix and nf_ram_hs.
// Rev 1.0
// ============================================================================
interface nf_ram_hs_if #(
   parameter int unsigned DATA_W = 32
);
   logic                  req;
   logic                  we;
   logic [31:0]           addr;
   logic [DATA_W/8-1:0]   be;
   logic [DATA_W-1:0]     wd;
   logic [DATA_W-1:0]     rd;
   logic                  ack;
   logic                  err;
   logic                  busy;

   modport master (
      output req, we, addr, be, wd,
      input  rd, ack, err, busy
   );

   modport slave (
      input  req, we, addr, be, wd,
      output rd, ack, err, busy
   );
endinterface
`default_nettype wire

// File: rtl/nf_ram_hs.sv
`default_nettype none
// ============================================================================
// nf_ram_hs : single-port word RAM, byte strobes, registered read, wait states.
// Rev 1.0
// ============================================================================
module nf_ram_hs #(
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned WAIT_ST = 0
) (
   input  logic       clk,
   input  logic       rst,
   nf_ram_hs_if.slave bus
);
   localparam int unsigned c_lanes    = DATA_W / 8;
   localparam int unsigned c_off_w    = $clog2(c_lanes);
   localparam int unsigned c_aw       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  c_cnt_init = (WAIT_ST > 0) ? 4'(WAIT_ST - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 we_q, we_d;
   logic [31:0]          idx_q, idx_d;
   logic [c_lanes-1:0]   be_q, be_d;
   logic [DATA_W-1:0]    wd_q, wd_d;
   logic                 err_q, err_d;
   logic [DATA_W-1:0]    rd_q;

   logic [DATA_W-1:0]    mem [DEPTH];

   logic                 accept;
   logic                 commit;
   logic [31:0]          live_idx;
   logic                 op_we;
   logic [31:0]          op_idx;
   logic [c_lanes-1:0]   op_be;
   logic [DATA_W-1:0]    op_wd;
   logic                 op_in_range;
   logic [c_aw-1:0]      op_word;

   assign live_idx = bus.addr >> c_off_w;
   assign accept   = bus.req && (state_q != ST_WAIT);

   // With no wait states the access commits on the accepting edge, so the
   // live bus fields feed the array; otherwise the latched copy does.
   always_comb begin
      op_we  = bus.we;
      op_idx = live_idx;
      op_be  = bus.be;
      op_wd  = bus.wd;
      if (state_q == ST_WAIT) begin
         op_we  = we_q;
         op_idx = idx_q;
         op_be  = be_q;
         op_wd  = wd_q;
      end
   end

   assign op_in_range = (op_idx < 32'(DEPTH));
   assign op_word     = op_idx[c_aw-1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      idx_d   = idx_q;
      be_d    = be_q;
      wd_d    = wd_q;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE, ST_RESP: begin
            state_d = ST_IDLE;
            if (accept) begin
               we_d  = bus.we;
               idx_d = live_idx;
               be_d  = bus.be;
               wd_d  = bus.wd;
               if (WAIT_ST == 0) begin
                  state_d = ST_RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = c_cnt_init;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      err_d = commit && !op_in_range;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         idx_q   <= 32'd0;
         be_q    <= '0;
         wd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
         be_q    <= be_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
      end
   end

   // Array contents survive reset; a reset edge suppresses any commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q <= '0;
      end else if (commit) begin
         if (!op_in_range) begin
            rd_q <= '0;
         end else if (op_we) begin
            for (int i = 0; i < int'(c_lanes); i++) begin
               if (op_be[i]) begin
                  mem[op_word][8*i +: 8] <= op_wd[8*i +: 8];
               end
            end
         end else begin
            rd_q <= mem[op_word];
         end
      end
   end

   assign bus.rd   = rd_q;
   assign bus.ack  = (state_q == ST_RESP);
   assign bus.err  = err_q;
   assign bus.busy = (state_q == ST_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_nf_ram_hs.sv
`default_nettype none
// ============================================================================
// tb_nf_ram_hs : directed bench for nf_ram_hs with wait_st = 0, 3 and 2.
// Rev 1.0
// ============================================================================
module tb_nf_ram_hs;
   logic        clk = 1'b0;
   logic        rst0, rst3, rst2;
   logic        req, we;
   logic [31:0] addr, wd;
   logic [3:0]  be;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   nf_ram_hs_if #(.DATA_W(32)) if0 ();
   nf_ram_hs_if #(.DATA_W(32)) if3 ();
   nf_ram_hs_if #(.DATA_W(32)) if2 ();

   assign if0.req = req;  assign if0.we = we;  assign if0.addr = addr;
   assign if0.be  = be;   assign if0.wd = wd;
   assign if3.req = req;  assign if3.we = we;  assign if3.addr = addr;
   assign if3.be  = be;   assign if3.wd = wd;
   assign if2.req = req;  assign if2.we = we;  assign if2.addr = addr;
   assign if2.be  = be;   assign if2.wd = wd;

   nf_ram_hs #(.DEPTH(64), .DATA_W(32), .WAIT_ST(0)) dut0 (.clk(clk), .rst(rst0), .bus(if0));
   nf_ram_hs #(.DEPTH(64), .DATA_W(32), .WAIT_ST(3)) dut3 (.clk(clk), .rst(rst3), .bus(if3));
   nf_ram_hs #(.DEPTH(64), .DATA_W(32), .WAIT_ST(2)) dut2 (.clk(clk), .rst(rst2), .bus(if2));

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [3:0]  b;
      logic [31:0] d;
      logic [31:0] rd;
      logic        err;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic smp(input int id, output logic a, output logic e, output logic b,
                      output logic [31:0] r);
      case (id)
         0:       begin a = if0.ack; e = if0.err; b = if0.busy; r = if0.rd; end
         3:       begin a = if3.ack; e = if3.err; b = if3.busy; r = if3.rd; end
         default: begin a = if2.ack; e = if2.err; b = if2.busy; r = if2.rd; end
      endcase
   endtask

   // Issue one access at a negedge, wait (bounded) for ack, check latency and results.
   task automatic acc(input int id, input int ws, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err, input string name);
      logic        sa, se, sb;
      logic [31:0] sr;
      bit          seen;
      int          lat;
      req = 1'b1; we = w; addr = a; be = b; wd = d;
      seen = 1'b0;
      lat  = 0;
      for (int k = 1; k <= 20 && !seen; k++) begin
         @(negedge clk);
         if (k == 1) req = 1'b0;
         smp(id, sa, se, sb, sr);
         if (sa === 1'b1) begin
            seen = 1'b1;
            lat  = k;
         end
      end
      chk({name, " ack"}, 32'(seen), 32'd1);
      if (seen) begin
         chk({name, " latency"}, 32'(lat), 32'(ws + 1));
         chk({name, " err"}, 32'(se), 32'(exp_err));
         chk({name, " rd"}, sr, exp_rd);
      end
      @(negedge clk);
      smp(id, sa, se, sb, sr);
      chk({name, " ack drop"}, 32'(sa), 32'd0);
      chk({name, " err drop"}, 32'(se), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t        vt[15];
      logic [31:0] bb_a[4], bb_d[4], bb_rd[4];
      logic        bb_w[4];
      logic        sa, se, sb;
      logic [31:0] sr;

      vt[0]  = '{1'b1, 32'h0000_0008, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      vt[1]  = '{1'b0, 32'h0000_0008, 4'hF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
      vt[2]  = '{1'b1, 32'h0000_0008, 4'h5, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0};
      vt[3]  = '{1'b0, 32'h0000_0008, 4'h0, 32'h0000_0000, 32'hDE22_BE44, 1'b0};
      vt[4]  = '{1'b1, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 32'hDE22_BE44, 1'b0};
      vt[5]  = '{1'b1, 32'h0000_0100, 4'hF, 32'h5555_5555, 32'h0000_0000, 1'b1};
      vt[6]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
      vt[7]  = '{1'b0, 32'h0000_0100, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b1};
      vt[8]  = '{1'b1, 32'h0000_0003, 4'h1, 32'h0000_00AA, 32'h0000_0000, 1'b0};
      vt[9]  = '{1'b0, 32'h0000_0002, 4'hF, 32'h0000_0000, 32'hCAFE_F0AA, 1'b0};
      vt[10] = '{1'b1, 32'h0000_00FC, 4'hF, 32'h1234_5678, 32'hCAFE_F0AA, 1'b0};
      vt[11] = '{1'b0, 32'h0000_00FF, 4'hF, 32'h0000_0000, 32'h1234_5678, 1'b0};
      vt[12] = '{1'b1, 32'h0000_00FC, 4'h0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0};
      vt[13] = '{1'b0, 32'h0000_00FC, 4'hF, 32'h0000_0000, 32'h1234_5678, 1'b0};
      vt[14] = '{1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b1};

      bb_w[0] = 1'b1; bb_a[0] = 32'h10; bb_d[0] = 32'hA0A0_A0A0; bb_rd[0] = 32'h0;
      bb_w[1] = 1'b1; bb_a[1] = 32'h14; bb_d[1] = 32'hB1B1_B1B1; bb_rd[1] = 32'h0;
      bb_w[2] = 1'b0; bb_a[2] = 32'h10; bb_d[2] = 32'h0;         bb_rd[2] = 32'hA0A0_A0A0;
      bb_w[3] = 1'b0; bb_a[3] = 32'h14; bb_d[3] = 32'h0;         bb_rd[3] = 32'hB1B1_B1B1;

      rst0 = 1'b1; rst3 = 1'b1; rst2 = 1'b1;
      req = 1'b0; we = 1'b0; addr = 32'h0; be = 4'h0; wd = 32'h0;
      repeat (3) @(negedge clk);

      // Reset state of all three instances.
      for (int id = 0; id < 4; id++) begin
         if (id != 1) begin
            smp(id, sa, se, sb, sr);
            chk($sformatf("reset%0d ack", id),  32'(sa), 32'd0);
            chk($sformatf("reset%0d err", id),  32'(se), 32'd0);
            chk($sformatf("reset%0d busy", id), 32'(sb), 32'd0);
            chk($sformatf("reset%0d rd", id),   sr, 32'd0);
         end
      end

      // wait_st=0: vector table.
      rst0 = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 15; i++) begin
         acc(0, 0, vt[i].w, vt[i].a, vt[i].b, vt[i].d, vt[i].rd, vt[i].err,
             $sformatf("vec%0d", i));
      end

      // wait_st=0: req held high for four back-to-back accesses.
      req = 1'b1; we = bb_w[0]; addr = bb_a[0]; be = 4'hF; wd = bb_d[0];
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         smp(0, sa, se, sb, sr);
         chk($sformatf("b2b%0d ack", k), 32'(sa), 32'd1);
         chk($sformatf("b2b%0d err", k), 32'(se), 32'd0);
         chk($sformatf("b2b%0d rd", k),  sr, bb_rd[k]);
         if (k < 3) begin
            we = bb_w[k+1]; addr = bb_a[k+1]; wd = bb_d[k+1];
         end else begin
            req = 1'b0;
         end
      end
      @(negedge clk);
      smp(0, sa, se, sb, sr);
      chk("b2b end ack", 32'(sa), 32'd0);
      rst0 = 1'b1;

      // wait_st=3: busy window, input changes while busy are ignored.
      rst3 = 1'b0;
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h20; be = 4'hF; wd = 32'h0F0F_0F0F;
      for (int c = 11; c <= 13; c++) begin
         @(negedge clk);
         smp(3, sa, se, sb, sr);
         chk($sformatf("ws3 c%0d busy", c), 32'(sb), 32'd1);
         chk($sformatf("ws3 c%0d ack", c),  32'(sa), 32'd0);
         req  = c[0];
         we   = ~c[0];
         addr = 32'h24;
         wd   = $urandom;
      end
      @(negedge clk);
      req = 1'b0;
      smp(3, sa, se, sb, sr);
      chk("ws3 c14 ack",  32'(sa), 32'd1);
      chk("ws3 c14 busy", 32'(sb), 32'd0);
      chk("ws3 c14 err",  32'(se), 32'd0);
      @(negedge clk);
      smp(3, sa, se, sb, sr);
      chk("ws3 c15 ack", 32'(sa), 32'd0);
      acc(3, 3, 1'b0, 32'h20,  4'hF, 32'h0, 32'h0F0F_0F0F, 1'b0, "ws3 read");
      acc(3, 3, 1'b0, 32'h100, 4'hF, 32'h0, 32'h0000_0000, 1'b1, "ws3 oor");
      rst3 = 1'b1;

      // wait_st=2: reset during WAIT aborts the write.
      rst2 = 1'b0;
      @(negedge clk);
      acc(2, 2, 1'b1, 32'h30, 4'hF, 32'h7777_7777, 32'h0, 1'b0, "ws2 wr");
      acc(2, 2, 1'b0, 32'h30, 4'hF, 32'h0, 32'h7777_7777, 1'b0, "ws2 rd");
      req = 1'b1; we = 1'b1; addr = 32'h30; be = 4'hF; wd = 32'h9999_9999;
      @(negedge clk);
      req  = 1'b0;
      rst2 = 1'b1;
      @(negedge clk);
      smp(2, sa, se, sb, sr);
      chk("ws2 abort busy", 32'(sb), 32'd0);
      rst2 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         smp(2, sa, se, sb, sr);
         chk($sformatf("ws2 abort ack%0d", k), 32'(sa), 32'd0);
      end
      acc(2, 2, 1'b0, 32'h30, 4'hF, 32'h0, 32'h7777_7777, 1'b0, "ws2 old data");

      // wait_st=2: reset in RESP drops ack but the write already committed.
      req = 1'b1; we = 1'b1; addr = 32'h34; be = 4'hF; wd = 32'h5A5A_5A5A;
      @(negedge clk);
      req = 1'b0;
      repeat (2) @(negedge clk);
      smp(2, sa, se, sb, sr);
      chk("ws2 resp ack", 32'(sa), 32'd1);
      rst2 = 1'b1;
      @(negedge clk);
      smp(2, sa, se, sb, sr);
      chk("ws2 resp rst ack", 32'(sa), 32'd0);
      chk("ws2 resp rst rd",  sr, 32'd0);
      rst2 = 1'b0;
      @(negedge clk);
      acc(2, 2, 1'b0, 32'h34, 4'hF, 32'h0, 32'h5A5A_5A5A, 1'b0, "ws2 resp kept");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
